mole_scheduler: RTL and testbench
=================================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter: WIDTH, 18, number of LED/switch lanes.
REQ-002 Parameter: SPAWN_CYCLES, 50000000, idle gap between targets, in clocks (>=1).
REQ-003 Parameter: ON_CYCLES, 50000000, target lifetime, in clocks (>=1).
REQ-004 Parameter: MAX_MISSES, 3, misses that end the game (1..15).
REQ-005 Parameter: SCORE_W, 8, score counter width.
REQ-006 Port: clk, input, 1, single system clock; all state on rising edge.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: start, input, 1, single-cycle start/restart pulse.
REQ-009 Port: rnd, input, 5, free-running random index from rng; resampled every cycle.
REQ-010 Port: edge_detect, input, WIDTH, per-switch single-cycle toggle pulses from switch_detector.
REQ-011 Port: leds, output, WIDTH, registered target display.
REQ-012 Port: score, output, SCORE_W, registered hit count.
REQ-013 Port: misses, output, 4, registered miss count.
REQ-014 Port: playing, output, 1, high in SPAWN_WAIT, PICK, ACTIVE.
REQ-015 Port: game_over, output, 1, high only in OVER.

Function
REQ-016 FSM states SHALL be IDLE, SPAWN_WAIT, PICK, ACTIVE, OVER; all outputs SHALL be registered.
REQ-017 IDLE: start -> SPAWN_WAIT next cycle, score and misses cleared, gap counter cleared.
REQ-018 SPAWN_WAIT SHALL last exactly SPAWN_CYCLES clocks, then -> PICK; leds all zero.
REQ-019 PICK: rnd < WIDTH -> latch target = rnd, ACTIVE next cycle with leds one-hot at target; rnd >= WIDTH -> stay in PICK, resample next cycle.
REQ-020 ACTIVE: edge_detect[target] -> score +1 (saturate at all-ones), leds cleared, SPAWN_WAIT next cycle.
REQ-021 ACTIVE: any edge_detect bit other than target, with target bit low -> miss.
REQ-022 ACTIVE: ON_CYCLES clocks elapse with no hit -> miss.
REQ-023 Miss: misses +1, leds cleared; new count == MAX_MISSES -> OVER, else -> SPAWN_WAIT.
REQ-024 Same-cycle target edge and timeout or wrong edge: hit SHALL win, exactly one score increment, no miss.
REQ-025 Multiple wrong edges in one cycle SHALL count as one miss.
REQ-026 edge_detect SHALL be ignored outside ACTIVE.
REQ-027 start SHALL be ignored in SPAWN_WAIT, PICK, ACTIVE.
REQ-028 OVER: leds all ones, score and misses held; start -> SPAWN_WAIT with score and misses cleared.
REQ-029 Lifetime and gap counters SHALL be wide enough for the parameter values; no wrap before terminal count.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, leds=0, score=0, misses=0, playing=0, game_over=0, counters=0, target=0, including mid-ACTIVE.
REQ-031 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
Bench parameters: SPAWN_CYCLES=4, ON_CYCLES=8, MAX_MISSES=3.
REQ-032 start at cycle 0, rnd=5 -> leds=18'h00020 from cycle 6; edge_detect[5] at cycle 8 -> score=1, leds=0 next cycle.
REQ-033 rnd=20,25 then 3 in PICK -> two resample cycles, then leds=18'h00008; no miss counted.
REQ-034 Target never hit three times -> misses 1,2,3; after the third miss game_over=1, leds=18'h3FFFF; start -> score=0, misses=0, playing=1.
REQ-035 Target=7, edge_detect=18'h00081 on the timeout cycle -> score +1, misses unchanged.
REQ-036 Target=2, edge_detect[9] pulse -> misses +1, leds cleared, SPAWN_WAIT; rst_n low mid-ACTIVE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: spawns one lit target at a time, scores hits on its switch,
// counts misses (wrong switch or timeout) and ends the game after MAX_MISSES misses.
module mole_scheduler #(
    parameter int unsigned WIDTH        = 18,
    parameter int unsigned SPAWN_CYCLES = 50000000,
    parameter int unsigned ON_CYCLES    = 50000000,
    parameter int unsigned MAX_MISSES   = 3,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4:0]         rnd,
    input  logic [WIDTH-1:0]   edge_detect,
    output logic [WIDTH-1:0]   leds,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               playing,
    output logic               game_over
);

    localparam int unsigned GAP_W  = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
    localparam int unsigned LIFE_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(SPAWN_CYCLES - 1);
    localparam logic [LIFE_W-1:0] LIFE_LAST  = LIFE_W'(ON_CYCLES - 1);
    localparam logic [3:0]        MISS_LIMIT = 4'(MAX_MISSES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_PICK   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   leds_q, leds_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [4:0]         target_q, target_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;

    logic [WIDTH-1:0] tgt_mask;
    logic             rnd_ok;
    logic             hit;
    logic             wrong;
    logic             timeout;
    logic [3:0]       miss_inc;

    assign tgt_mask = WIDTH'(1) << target_q;
    assign rnd_ok   = 32'(rnd) < WIDTH;
    assign hit      = |(edge_detect & tgt_mask);
    // Any number of stray switches in one cycle is a single miss; a hit overrides it.
    assign wrong    = |(edge_detect & ~tgt_mask);
    assign timeout  = (life_q == LIFE_LAST);
    assign miss_inc = misses_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        leds_d   = leds_q;
        score_d  = score_q;
        misses_d = misses_q;
        gap_d    = gap_q;
        life_d   = life_q;
        target_d = target_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_WAIT;
                    leds_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                    gap_d    = '0;
                    life_d   = '0;
                end
            end
            S_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_PICK;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_PICK: begin
                if (rnd_ok) begin
                    state_d  = S_ACTIVE;
                    target_d = rnd;
                    life_d   = '0;
                    leds_d   = WIDTH'(1) << rnd;
                end
            end
            S_ACTIVE: begin
                if (hit) begin
                    state_d = S_WAIT;
                    score_d = (&score_q) ? score_q : score_q + 1'b1;
                    leds_d  = '0;
                    gap_d   = '0;
                    life_d  = '0;
                end else if (wrong || timeout) begin
                    misses_d = miss_inc;
                    gap_d    = '0;
                    life_d   = '0;
                    if (miss_inc == MISS_LIMIT) begin
                        state_d = S_OVER;
                        leds_d  = '1;
                    end else begin
                        state_d = S_WAIT;
                        leds_d  = '0;
                    end
                end else begin
                    life_d = life_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                leds_d  = '0;
                gap_d   = '0;
                life_d  = '0;
            end
        endcase

        playing_d   = (state_d == S_WAIT) || (state_d == S_PICK) || (state_d == S_ACTIVE);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            leds_q      <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            gap_q       <= '0;
            life_q      <= '0;
            target_q    <= '0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            leds_q      <= leds_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            gap_q       <= gap_d;
            life_q      <= life_d;
            target_q    <= target_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign leds      = leds_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed and randomized bench for mole_scheduler against a phase/timer reference model.
module tb_mole_scheduler;

    localparam int unsigned WIDTH = 18;
    localparam int unsigned SPAWN = 4;
    localparam int unsigned ON    = 8;
    localparam int unsigned MAXM  = 3;
    localparam int unsigned SW    = 8;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_PICK = 2;
    localparam int P_ACT  = 3;
    localparam int P_OVER = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [4:0]       rnd = '0;
    logic [WIDTH-1:0] edge_detect = '0;
    logic [WIDTH-1:0] leds;
    logic [SW-1:0]    score;
    logic [3:0]       misses;
    logic             playing;
    logic             game_over;

    int checks = 0;
    int fails  = 0;

    // Reference model: game phase, cycles spent in it, current target and counters.
    int m_phase  = P_IDLE;
    int m_cnt    = 0;
    int m_target = 0;
    int m_score  = 0;
    int m_misses = 0;

    mole_scheduler #(
        .WIDTH       (WIDTH),
        .SPAWN_CYCLES(SPAWN),
        .ON_CYCLES   (ON),
        .MAX_MISSES  (MAXM),
        .SCORE_W     (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rnd        (rnd),
        .edge_detect(edge_detect),
        .leds       (leds),
        .score      (score),
        .misses     (misses),
        .playing    (playing),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_cnt    = 0;
        m_target = 0;
        m_score  = 0;
        m_misses = 0;
    endtask

    task automatic model_step();
        bit hit;
        bit wrong;
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (start) begin
                    m_phase  = P_WAIT;
                    m_cnt    = 0;
                    m_score  = 0;
                    m_misses = 0;
                end
            end
            P_WAIT: begin
                m_cnt++;
                if (m_cnt == SPAWN) m_phase = P_PICK;
            end
            P_PICK: begin
                if (int'(rnd) < WIDTH) begin
                    m_target = int'(rnd);
                    m_phase  = P_ACT;
                    m_cnt    = 0;
                end
            end
            default: begin
                hit   = edge_detect[m_target];
                wrong = (edge_detect & ~(WIDTH'(1) << m_target)) != '0;
                m_cnt++;
                if (hit) begin
                    m_score = (m_score == 255) ? 255 : m_score + 1;
                    m_phase = P_WAIT;
                    m_cnt   = 0;
                end else if (wrong || m_cnt == ON) begin
                    m_misses++;
                    m_phase = (m_misses == MAXM) ? P_OVER : P_WAIT;
                    m_cnt   = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        logic [WIDTH-1:0] e_leds;
        if (m_phase == P_ACT) e_leds = WIDTH'(1) << m_target;
        else if (m_phase == P_OVER) e_leds = '1;
        else e_leds = '0;
        check("leds", 32'(leds), 32'(e_leds));
        check("score", 32'(score), 32'(m_score));
        check("misses", 32'(misses), 32'(m_misses));
        check("playing", 32'(playing),
              32'(m_phase == P_WAIT || m_phase == P_PICK || m_phase == P_ACT));
        check("game_over", 32'(game_over), 32'(m_phase == P_OVER));
    endtask

    // One clock: DUT and model consume the same inputs, then pulses drop.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        start       = 1'b0;
        edge_detect = '0;
    endtask

    task automatic wait_phase(input int ph, input int limit);
        int n = 0;
        while (m_phase != ph && n < limit) begin
            cycle();
            n++;
        end
        check("wait_phase_timeout", 32'(m_phase), 32'(ph));
    endtask

    task automatic wait_timeout_cycle(input int limit);
        int n = 0;
        while (!(m_phase == P_ACT && m_cnt == ON - 1) && n < limit) begin
            cycle();
            n++;
        end
        check("wait_timeout_cycle", 32'(m_cnt), 32'(ON - 1));
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Held in IDLE after reset without start.
        repeat (3) cycle();
        check("idle_hold_playing", 32'(playing), 32'd0);

        // Start at cycle 0, rnd=5: lit from cycle 6, hit at cycle 8.
        rnd   = 5'd5;
        start = 1'b1;
        repeat (6) cycle();
        check("first_target_leds", 32'(leds), 32'h00020);
        repeat (2) cycle();
        edge_detect = WIDTH'(1) << 5;
        cycle();
        check("first_hit_score", 32'(score), 32'd1);
        check("first_hit_leds", 32'(leds), 32'd0);

        // Out-of-range picks resample.
        rnd = 5'd20;
        wait_phase(P_PICK, 10);
        cycle();
        check("resample1_leds", 32'(leds), 32'd0);
        rnd = 5'd25;
        cycle();
        check("resample2_playing", 32'(playing), 32'd1);
        rnd = 5'd3;
        cycle();
        check("resample_leds", 32'(leds), 32'h00008);
        check("resample_no_miss", 32'(misses), 32'd0);
        edge_detect = WIDTH'(1) << 3;
        cycle();

        // Three timeouts end the game; OVER ignores switches and restarts on start.
        rnd = 5'd11;
        wait_phase(P_OVER, 100);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_leds", 32'(leds), 32'h3FFFF);
        check("over_misses", 32'(misses), 32'd3);
        edge_detect = '1;
        cycle();
        cycle();
        start = 1'b1;
        cycle();
        check("restart_score", 32'(score), 32'd0);
        check("restart_misses", 32'(misses), 32'd0);
        check("restart_playing", 32'(playing), 32'd1);

        // Hit plus stray edge on the timeout cycle: hit wins.
        rnd = 5'd7;
        wait_phase(P_ACT, 20);
        wait_timeout_cycle(20);
        edge_detect = 18'h00081;
        cycle();
        check("timeout_hit_score", 32'(score), 32'd1);
        check("timeout_hit_misses", 32'(misses), 32'd0);

        // Wrong switch is a miss; then reset asynchronously mid-ACTIVE.
        rnd = 5'd2;
        wait_phase(P_ACT, 20);
        edge_detect = WIDTH'(1) << 9;
        cycle();
        check("wrong_misses", 32'(misses), 32'd1);
        check("wrong_leds", 32'(leds), 32'd0);
        check("wrong_playing", 32'(playing), 32'd1);
        wait_phase(P_ACT, 20);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds), 32'd0);
        check("async_rst_score", 32'(score), 32'd0);
        check("async_rst_misses", 32'(misses), 32'd0);
        check("async_rst_playing", 32'(playing), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Score saturation: hit every target on its first lit cycle.
        start = 1'b1;
        cycle();
        for (int h = 0; h < 260; h++) begin
            rnd = 5'($urandom_range(0, 17));
            wait_phase(P_ACT, 20);
            edge_detect = WIDTH'(1) << m_target;
            cycle();
        end
        check("score_saturated", 32'(score), 32'hFF);

        // Randomized play.
        for (int i = 0; i < 600; i++) begin
            rnd   = 5'($urandom_range(0, 31));
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) edge_detect = WIDTH'($urandom) & WIDTH'($urandom);
            else if (m_phase == P_ACT && $urandom_range(0, 5) == 0)
                edge_detect = WIDTH'(1) << m_target;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
